// File: rtl/cv32e40p_sleep_ctrl.sv
// Sleep sequencer for WFI-driven core sleep with the cluster option disabled.
// After a sleep request it drains IF/LSU/APU activity, then puts the core to
// sleep and drops the core clock enable. An interrupt or debug request wakes
// it, and a fixed settle window runs before the core resumes. It returns
// acknowledge, abort and wake-done pulses to the controller FSM.
//
// state | meaning
// ------+-------------------------------------------------------------
// RESET | out of reset, waiting for the first fetch enable
// RUN   | core running normally
// DRAIN | sleep requested, waiting for outstanding activity to finish
// SLEEP | core asleep, core clock gated off
// WAKE  | wake event seen, settle window before resuming
module cv32e40p_sleep_ctrl #(
    parameter int unsigned WAKE_CYCLES   = 2,
    parameter int unsigned DRAIN_TIMEOUT = 16
) (
    input  logic       clk_ungated_i,
    input  logic       rst_n,
    input  logic       fetch_enable_i,
    input  logic       sleep_req_i,
    input  logic       if_busy_i,
    input  logic       lsu_busy_i,
    input  logic       apu_busy_i,
    input  logic       irq_pending_i,
    input  logic       debug_req_i,
    input  logic       debug_no_sleep_i,
    output logic       fetch_enable_o,
    output logic       clock_en_o,
    output logic       core_sleep_o,
    output logic       sleep_ack_o,
    output logic       sleep_abort_o,
    output logic       wake_done_o,
    output logic [2:0] state_o
);

    localparam logic [2:0] ST_RESET = 3'b000;
    localparam logic [2:0] ST_RUN   = 3'b001;
    localparam logic [2:0] ST_DRAIN = 3'b010;
    localparam logic [2:0] ST_SLEEP = 3'b011;
    localparam logic [2:0] ST_WAKE  = 3'b100;

    // Both windows are counted in an 8-bit down-counter.
    if (WAKE_CYCLES == 0 || WAKE_CYCLES > 255) begin : g_bad_wake_cycles
        $error("cv32e40p_sleep_ctrl: WAKE_CYCLES must be in 1..255");
    end
    if (DRAIN_TIMEOUT > 255) begin : g_bad_drain_timeout
        $error("cv32e40p_sleep_ctrl: DRAIN_TIMEOUT must be in 0..255");
    end

    localparam logic [7:0] WAKE_LOAD   = 8'(WAKE_CYCLES);
    localparam logic [7:0] DRAIN_LOAD  = 8'(DRAIN_TIMEOUT);
    localparam logic       HAS_TIMEOUT = (DRAIN_TIMEOUT != 0);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fetch_en_q, fetch_en_d;
    logic       wake_evt, busy;
    logic       clock_en;

    assign wake_evt   = irq_pending_i | debug_req_i;
    assign busy       = if_busy_i | lsu_busy_i | apu_busy_i;
    assign fetch_en_d = fetch_en_q | fetch_enable_i;

    // Next-state, counter and output decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        clock_en      = 1'b0;
        core_sleep_o  = 1'b0;
        sleep_ack_o   = 1'b0;
        sleep_abort_o = 1'b0;
        wake_done_o   = 1'b0;
        case (state_q)
            ST_RESET: begin
                // Combinational so the very first fetch sees a live clock.
                clock_en = fetch_enable_i;
                if (fetch_enable_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                clock_en = 1'b1;
                if (sleep_req_i && !debug_no_sleep_i && !wake_evt) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                clock_en = 1'b1;
                if (wake_evt || !sleep_req_i || debug_no_sleep_i) begin
                    sleep_abort_o = 1'b1;
                    state_d       = ST_RUN;
                end else if (!busy) begin
                    sleep_ack_o = 1'b1;
                    state_d     = ST_SLEEP;
                end else if (HAS_TIMEOUT && cnt_q == 8'd1) begin
                    sleep_abort_o = 1'b1;
                    state_d       = ST_RUN;
                end else if (HAS_TIMEOUT) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SLEEP: begin
                // Wake is zero-latency on the clock gate.
                core_sleep_o = !wake_evt;
                clock_en     = wake_evt;
                if (wake_evt) begin
                    state_d = ST_WAKE;
                    cnt_d   = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                clock_en = 1'b1;
                cnt_d    = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    wake_done_o = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Outputs must all be low while reset is asserted, including the
    // RESET-state enable that follows fetch_enable_i combinationally.
    assign clock_en_o     = clock_en & rst_n;
    assign fetch_enable_o = fetch_en_q;
    assign state_o        = state_q;

    // State, counter and sticky fetch enable registers.
    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            cnt_q      <= 8'd0;
            fetch_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fetch_en_q <= fetch_en_d;
        end
    end

endmodule

// File: tb/tb_cv32e40p_sleep_ctrl.sv
// Self-checking bench for cv32e40p_sleep_ctrl: directed scenarios plus a
// randomized run, checked against a cycle-level behavioural model.
module tb_cv32e40p_sleep_ctrl;

    localparam int WC = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic fe_i, req, if_busy, lsu_busy, apu_busy, irq, dbg, dns;
    logic fe_o, ce_o, sl_o, ack_o, ab_o, dn_o;
    logic [2:0] st_o;
    logic nt_fe_o, nt_ce_o, nt_sl_o, nt_ack_o, nt_ab_o, nt_dn_o;
    logic [2:0] nt_st_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cv32e40p_sleep_ctrl #(.WAKE_CYCLES(WC), .DRAIN_TIMEOUT(TO)) u_dut (
        .clk_ungated_i(clk), .rst_n(rst_n), .fetch_enable_i(fe_i),
        .sleep_req_i(req), .if_busy_i(if_busy), .lsu_busy_i(lsu_busy),
        .apu_busy_i(apu_busy), .irq_pending_i(irq), .debug_req_i(dbg),
        .debug_no_sleep_i(dns), .fetch_enable_o(fe_o), .clock_en_o(ce_o),
        .core_sleep_o(sl_o), .sleep_ack_o(ack_o), .sleep_abort_o(ab_o),
        .wake_done_o(dn_o), .state_o(st_o)
    );

    cv32e40p_sleep_ctrl #(.WAKE_CYCLES(WC), .DRAIN_TIMEOUT(0)) u_dut_nt (
        .clk_ungated_i(clk), .rst_n(rst_n), .fetch_enable_i(fe_i),
        .sleep_req_i(req), .if_busy_i(if_busy), .lsu_busy_i(lsu_busy),
        .apu_busy_i(apu_busy), .irq_pending_i(irq), .debug_req_i(dbg),
        .debug_no_sleep_i(dns), .fetch_enable_o(nt_fe_o), .clock_en_o(nt_ce_o),
        .core_sleep_o(nt_sl_o), .sleep_ack_o(nt_ack_o), .sleep_abort_o(nt_ab_o),
        .wake_done_o(nt_dn_o), .state_o(nt_st_o)
    );

    // ---------------- behavioural model ----------------
    // Modes are named by the trace codes the controller must report; time in
    // a mode is counted upward and compared against the window lengths.
    localparam int M_RESET = 0, M_RUN = 1, M_DRAIN = 2, M_SLEEP = 3, M_WAKE = 4;
    int   m_mode, m_spent, m_next;
    bit   m_fe;
    logic [8:0] exp_v;

    function automatic logic [8:0] obs();
        return {st_o, fe_o, ce_o, sl_o, ack_o, ab_o, dn_o};
    endfunction

    task automatic model_reset();
        m_mode = M_RESET; m_spent = 0; m_fe = 0;
    endtask

    task automatic model_eval();
        bit wake, bsy, ce, sl, ack, ab, dn;
        wake = irq | dbg;
        bsy  = if_busy | lsu_busy | apu_busy;
        ce = 0; sl = 0; ack = 0; ab = 0; dn = 0;
        m_next = m_mode;
        case (m_mode)
            M_RESET: begin ce = fe_i; if (fe_i) m_next = M_RUN; end
            M_RUN: begin
                ce = 1;
                if (req && !dns && !wake) m_next = M_DRAIN;
            end
            M_DRAIN: begin
                ce = 1;
                if (wake || !req || dns) begin ab = 1; m_next = M_RUN; end
                else if (!bsy) begin ack = 1; m_next = M_SLEEP; end
                else if (TO != 0 && m_spent + 1 == TO) begin ab = 1; m_next = M_RUN; end
            end
            M_SLEEP: begin sl = !wake; ce = wake; if (wake) m_next = M_WAKE; end
            default: begin
                ce = 1;
                if (m_spent + 1 == WC) begin dn = 1; m_next = M_RUN; end
            end
        endcase
        exp_v = {3'(m_mode), m_fe, ce, sl, ack, ab, dn};
    endtask

    task automatic model_next();
        if (fe_i) m_fe = 1;
        if (m_next != m_mode) m_spent = 0; else m_spent++;
        m_mode = m_next;
    endtask

    // Inputs are driven at posedge+1; outputs are sampled at posedge+5.
    task automatic settle();
        #4;
        model_eval();
    endtask

    task automatic adv();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fe_i = 0; req = 0; if_busy = 0; lsu_busy = 0; apu_busy = 0;
        irq = 0; dbg = 0; dns = 0;
    endtask

    // Asynchronous reset mid-cycle, then require a fresh fetch enable.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 0;
        clear_inputs();
        fe_i = 1;
        #1;
        checks++; if (obs() !== 9'b0) begin errors++; $display("FAIL %s_rst_zero: got %b expected %b", tag, obs(), 9'b0); end
        fe_i = 0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (obs() !== exp_v) begin errors++; $display("FAIL %s_hold_model: got %b expected %b", tag, obs(), exp_v); end
            checks++; if (st_o !== 3'b000 || ce_o !== 1'b0) begin errors++; $display("FAIL %s_hold_reset: got st=%b ce=%b expected st=000 ce=0", tag, st_o, ce_o); end
            adv();
        end
        fe_i = 1;
        settle();
        checks++; if (obs() !== exp_v) begin errors++; $display("FAIL %s_fe_model: got %b expected %b", tag, obs(), exp_v); end
        checks++; if (ce_o !== 1'b1) begin errors++; $display("FAIL %s_fe_clock: got %b expected 1", tag, ce_o); end
        adv();
        fe_i = 0;
        settle();
        checks++; if (st_o !== 3'b001 || fe_o !== 1'b1) begin errors++; $display("FAIL %s_run: got st=%b fe=%b expected st=001 fe=1", tag, st_o, fe_o); end
        adv();
    endtask

    // From RUN, go to SLEEP via a zero-length drain.
    task automatic enter_sleep(input string tag);
        req = 1;
        settle(); adv();
        settle();
        checks++; if (obs() !== exp_v || ack_o !== 1'b1) begin errors++; $display("FAIL %s_enter_ack: got %b expected %b", tag, obs(), exp_v); end
        adv();
        req = 0;
        settle();
        checks++; if (st_o !== 3'b011 || sl_o !== 1'b1 || ce_o !== 1'b0) begin errors++; $display("FAIL %s_enter_sleep: got st=%b sl=%b ce=%b expected 011 1 0", tag, st_o, sl_o, ce_o); end
        adv();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 0; clear_inputs(); fe_i = 1;
        #1;
        checks++; if (obs() !== 9'b0) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs(), 9'b0); end
        fe_i = 0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        for (int c = 0; c < 5; c++) begin
            fe_i = (c == 3);
            settle();
            checks++; if (obs() !== exp_v) begin errors++; $display("FAIL reset_model c%0d: got %b expected %b", c, obs(), exp_v); end
            if (c <= 2) begin
                checks++; if (ce_o !== 1'b0) begin errors++; $display("FAIL reset_clock_off c%0d: got %b expected 0", c, ce_o); end
            end else if (c == 3) begin
                checks++; if (ce_o !== 1'b1) begin errors++; $display("FAIL reset_clock_on: got %b expected 1", ce_o); end
            end else begin
                checks++; if (st_o !== 3'b001 || fe_o !== 1'b1) begin errors++; $display("FAIL reset_to_run: got st=%b fe=%b expected 001 1", st_o, fe_o); end
            end
            adv();
        end
    endtask

    task automatic test_drain_ack();
        req = 1; lsu_busy = 1;
        settle(); adv();
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) lsu_busy = 0;
            settle();
            checks++; if (obs() !== exp_v) begin errors++; $display("FAIL drain_model d%0d: got %b expected %b", i, obs(), exp_v); end
            checks++; if (st_o !== 3'b010 || ack_o !== (i == 4)) begin errors++; $display("FAIL drain_ack d%0d: got st=%b ack=%b expected 010 %0d", i, st_o, ack_o, i == 4); end
            adv();
        end
        req = 0;
        settle();
        checks++; if (st_o !== 3'b011 || sl_o !== 1'b1 || ce_o !== 1'b0) begin errors++; $display("FAIL drain_sleep: got st=%b sl=%b ce=%b expected 011 1 0", st_o, sl_o, ce_o); end
        adv();
    endtask

    task automatic test_wake();
        for (int src = 0; src < 2; src++) begin
            if (src == 1) enter_sleep("wake_dbg");
            settle(); adv();
            if (src == 0) irq = 1; else dbg = 1;
            settle();
            checks++; if (obs() !== exp_v) begin errors++; $display("FAIL wake_model s%0d: got %b expected %b", src, obs(), exp_v); end
            checks++; if (ce_o !== 1'b1 || sl_o !== 1'b0 || st_o !== 3'b011) begin errors++; $display("FAIL wake_instant s%0d: got ce=%b sl=%b st=%b expected 1 0 011", src, ce_o, sl_o, st_o); end
            adv();
            for (int w = 1; w <= 2; w++) begin
                settle();
                checks++; if (obs() !== exp_v) begin errors++; $display("FAIL wake_cycle_model s%0d w%0d: got %b expected %b", src, w, obs(), exp_v); end
                checks++; if (st_o !== 3'b100 || dn_o !== (w == 2) || ce_o !== 1'b1) begin errors++; $display("FAIL wake_cycle s%0d w%0d: got st=%b done=%b ce=%b", src, w, st_o, dn_o, ce_o); end
                adv();
            end
            irq = 0; dbg = 0;
            settle();
            checks++; if (st_o !== 3'b001) begin errors++; $display("FAIL wake_resume s%0d: got %b expected 001", src, st_o); end
            adv();
        end
    endtask

    task automatic test_timeout();
        int acks = 0;
        req = 1; lsu_busy = 1;
        settle(); adv();
        for (int i = 1; i <= TO; i++) begin
            settle();
            if (ack_o === 1'b1) acks++;
            checks++; if (obs() !== exp_v) begin errors++; $display("FAIL timeout_model d%0d: got %b expected %b", i, obs(), exp_v); end
            checks++; if (st_o !== 3'b010 || ab_o !== (i == TO)) begin errors++; $display("FAIL timeout_abort d%0d: got st=%b abort=%b", i, st_o, ab_o); end
            adv();
        end
        req = 0; lsu_busy = 0;
        settle();
        checks++; if (st_o !== 3'b001 || acks != 0) begin errors++; $display("FAIL timeout_return: got st=%b acks=%0d expected 001 0", st_o, acks); end
        adv();
    endtask

    task automatic test_no_timeout();
        int bad = 0;
        async_reset("nt");
        req = 1; lsu_busy = 1;
        settle(); adv();
        for (int i = 0; i < 120; i++) begin
            settle();
            checks++; if (obs() !== exp_v) begin errors++; $display("FAIL nt_main_model i%0d: got %b expected %b", i, obs(), exp_v); end
            if (nt_st_o !== 3'b010 || nt_ab_o !== 1'b0 || nt_ack_o !== 1'b0) bad++;
            adv();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL nt_persist: got %0d bad cycles expected 0", bad); end
        req = 0; lsu_busy = 0;
        settle();
        checks++; if (nt_ab_o !== 1'b1) begin errors++; $display("FAIL nt_release_abort: got %b expected 1", nt_ab_o); end
        adv();
    endtask

    task automatic test_drain_irq_race();
        int sleeps = 0;
        req = 1; lsu_busy = 1;
        settle(); adv();
        settle(); adv();
        lsu_busy = 0; irq = 1;
        settle();
        if (sl_o === 1'b1) sleeps++;
        checks++; if (obs() !== exp_v) begin errors++; $display("FAIL race_model: got %b expected %b", obs(), exp_v); end
        checks++; if (ab_o !== 1'b1 || ack_o !== 1'b0) begin errors++; $display("FAIL race_pulses: got abort=%b ack=%b expected 1 0", ab_o, ack_o); end
        adv();
        req = 0; irq = 0;
        settle();
        if (sl_o === 1'b1) sleeps++;
        checks++; if (st_o !== 3'b001 || sleeps != 0) begin errors++; $display("FAIL race_run: got st=%b sleeps=%0d expected 001 0", st_o, sleeps); end
        adv();
    endtask

    task automatic test_debug_no_sleep();
        int bad = 0;
        req = 1; dns = 1;
        for (int i = 0; i < 30; i++) begin
            settle();
            if (st_o !== 3'b001) bad++;
            checks++; if (obs() !== exp_v) begin errors++; $display("FAIL dns_model i%0d: got %b expected %b", i, obs(), exp_v); end
            adv();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL dns_stay_run: got %0d cycles off RUN expected 0", bad); end
        req = 0; dns = 0;
    endtask

    task automatic test_reset_mid_op();
        enter_sleep("rst_sleep");
        settle(); adv();
        async_reset("mid_sleep");
        enter_sleep("rst_wake");
        irq = 1;
        settle(); adv();
        settle();
        checks++; if (st_o !== 3'b100) begin errors++; $display("FAIL mid_wake_state: got %b expected 100", st_o); end
        async_reset("mid_wake");
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            fe_i     = ($urandom_range(0, 15) == 0);
            req      = ($urandom_range(0, 3) != 0);
            dns      = ($urandom_range(0, 15) == 0);
            irq      = ($urandom_range(0, 9) == 0);
            dbg      = ($urandom_range(0, 19) == 0);
            if (m_mode == M_SLEEP) begin
                if_busy = 0; lsu_busy = 0; apu_busy = 0;
            end else begin
                if_busy  = ($urandom_range(0, 3) == 0);
                lsu_busy = ($urandom_range(0, 2) == 0);
                apu_busy = ($urandom_range(0, 5) == 0);
            end
            settle();
            checks++; if (obs() !== exp_v) begin errors++; $display("FAIL random_model i%0d: got %b expected %b", i, obs(), exp_v); end
            adv();
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_drain_ack();
        test_wake();
        test_timeout();
        test_drain_irq_race();
        test_debug_no_sleep();
        test_reset_mid_op();
        test_no_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
